// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control for the 5-stage MIPS core: load-use stall, branch
// flush, and a multi-cycle mult/div freeze, with a saturating stall counter.
module hazard_ctrl_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memtoreg,
  input  logic             ex_is_muldiv,
  input  logic             branch_taken,
  output logic             pc_le,
  output logic             if_id_le,
  output logic             if_id_clear,
  output logic             id_ex_le,
  output logic             id_ex_clear,
  output logic             ex_mem_le,
  output logic             ex_mem_clear,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN = 1'b0, MULDIV = 1'b1} state_t;

  localparam bit         MULDIV_EN = (MULDIV_CYCLES > 1);
  localparam logic [3:0] CNT_LOAD  = 4'(MULDIV_CYCLES - 2);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             muldiv_stall;
  logic             load_use;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_le        = 1'b1;
    if_id_le     = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_le     = 1'b1;
    id_ex_clear  = 1'b0;
    ex_mem_le    = 1'b1;
    ex_mem_clear = 1'b0;

    muldiv_stall = ((state_q == RUN) && ex_is_muldiv && MULDIV_EN) ||
                   ((state_q == MULDIV) && (cnt_q != 4'd0));
    load_use     = (state_q == RUN) && !muldiv_stall && ex_memtoreg &&
                   (ex_rt != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_rt)) ||
                    (id_uses_rt && (id_rt == ex_rt)));

    if (reset) begin
      pc_le        = 1'b0;
      if_id_le     = 1'b0;
      if_id_clear  = 1'b1;
      id_ex_le     = 1'b0;
      id_ex_clear  = 1'b1;
      ex_mem_le    = 1'b0;
      ex_mem_clear = 1'b1;
    end else if (muldiv_stall) begin
      pc_le        = 1'b0;
      if_id_le     = 1'b0;
      id_ex_le     = 1'b0;
      ex_mem_le    = 1'b0;
      ex_mem_clear = 1'b1;
      if (state_q == RUN) begin
        state_d = MULDIV;
        cnt_d   = CNT_LOAD;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (state_q == MULDIV) begin
      // Final EX cycle of the op: front end moves again, outputs stay default.
      state_d = RUN;
    end else if (load_use) begin
      pc_le       = 1'b0;
      if_id_le    = 1'b0;
      id_ex_clear = 1'b1;
    end else if (branch_taken) begin
      if_id_clear = 1'b1;
    end

    stall_d = stall_q;
    if (!pc_le && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  assign muldiv_busy  = !reset && (state_q == MULDIV);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios then random traffic, checked
// against a cycle-level model of mult/div occupancy and hazard rules.
module tb_hazard_ctrl_unit;

  localparam int N  = 4;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, ex_memtoreg, ex_is_muldiv, branch_taken;

  logic pc_le, if_id_le, if_id_clear, id_ex_le, id_ex_clear;
  logic ex_mem_le, ex_mem_clear, muldiv_busy;
  logic [15:0] stall_cycles;

  logic s_pc_le, s_if_id_le, s_if_id_clear, s_id_ex_le, s_id_ex_clear;
  logic s_ex_mem_le, s_ex_mem_clear, s_muldiv_busy;
  logic [SW-1:0] s_stall_cycles;

  int compared   = 0;
  int mismatched = 0;

  // Model state: cycles the current mult/div still spends in EX after its first.
  int md_left   = 0;
  int exp_stall = 0;
  int exp_sat   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MULDIV_CYCLES(N), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rt(ex_rt),
    .ex_memtoreg(ex_memtoreg), .ex_is_muldiv(ex_is_muldiv),
    .branch_taken(branch_taken), .pc_le(pc_le), .if_id_le(if_id_le),
    .if_id_clear(if_id_clear), .id_ex_le(id_ex_le), .id_ex_clear(id_ex_clear),
    .ex_mem_le(ex_mem_le), .ex_mem_clear(ex_mem_clear),
    .muldiv_busy(muldiv_busy), .stall_cycles(stall_cycles)
  );

  hazard_ctrl_unit #(.MULDIV_CYCLES(N), .CNT_W(SW)) dut_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rt(ex_rt),
    .ex_memtoreg(ex_memtoreg), .ex_is_muldiv(ex_is_muldiv),
    .branch_taken(branch_taken), .pc_le(s_pc_le), .if_id_le(s_if_id_le),
    .if_id_clear(s_if_id_clear), .id_ex_le(s_id_ex_le),
    .id_ex_clear(s_id_ex_clear), .ex_mem_le(s_ex_mem_le),
    .ex_mem_clear(s_ex_mem_clear), .muldiv_busy(s_muldiv_busy),
    .stall_cycles(s_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int rs, input int rt, input bit urs, input bit urt,
                       input int xrt, input bit mtr, input bit md, input bit br);
    id_rs        = 5'(rs);
    id_rt        = 5'(rt);
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    ex_rt        = 5'(xrt);
    ex_memtoreg  = mtr;
    ex_is_muldiv = md;
    branch_taken = br;
  endtask

  task automatic apply_reset(input bit v);
    reset = v;
    if (v) begin
      md_left   = 0;
      exp_stall = 0;
      exp_sat   = 0;
    end
  endtask

  // Expected {pc_le, if_id_le, if_id_clear, id_ex_le, id_ex_clear,
  //           ex_mem_le, ex_mem_clear, muldiv_busy}.
  task automatic model_comb(output logic [7:0] ctl);
    bit mds, lu, fl;
    if (reset) begin
      ctl = 8'b0010_1010;
    end else begin
      mds = (md_left == 0 && ex_is_muldiv && N > 1) || (md_left > 1);
      lu  = (md_left == 0) && !mds && ex_memtoreg && (ex_rt != 0) &&
            ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
      fl  = (md_left == 0) && !mds && !lu && branch_taken;
      ctl = {!(mds || lu), !(mds || lu), fl, !mds, lu, !mds, mds, md_left > 0};
    end
  endtask

  task automatic cycle(input string tag);
    logic [7:0] e;
    bit start;
    model_comb(e);
    @(negedge clk);
    check({tag, ".ctl"},
          {24'd0, pc_le, if_id_le, if_id_clear, id_ex_le, id_ex_clear,
           ex_mem_le, ex_mem_clear, muldiv_busy}, {24'd0, e});
    check({tag, ".stall"}, {16'd0, stall_cycles}, 32'(exp_stall));
    check({tag, ".sat"}, {29'd0, s_stall_cycles}, 32'(exp_sat));
    @(posedge clk);
    if (!reset) begin
      if (!e[7]) begin
        if (exp_stall < 65535) exp_stall++;
        if (exp_sat < (1 << SW) - 1) exp_sat++;
      end
      start = (md_left == 0) && ex_is_muldiv && (N > 1);
      if (md_left > 0) md_left--;
      else if (start) md_left = N - 1;
    end
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    apply_reset(1);
    repeat (2) @(posedge clk);
    #1;
    cycle("reset");
    apply_reset(0);
    cycle("idle");

    // Reset in the middle of normal traffic, then release.
    drive(3, 4, 1, 1, 7, 0, 0, 1);
    cycle("pre_rst");
    apply_reset(1);
    cycle("mid_rst");
    apply_reset(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("post_rst");

    // lw $5 in EX, add in ID reading $5, then bubble in EX.
    drive(5, 0, 1, 0, 5, 1, 0, 0);
    cycle("lu_rs");
    drive(5, 0, 1, 0, 0, 0, 0, 0);
    cycle("lu_after");

    // No stall for $0 destination or an unused rt match.
    drive(0, 0, 1, 1, 0, 1, 0, 0);
    cycle("lu_zero");
    drive(0, 5, 1, 0, 5, 1, 0, 0);
    cycle("lu_rt_unused");
    drive(9, 6, 0, 1, 6, 1, 0, 0);
    cycle("lu_rt");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("idle2");

    // Single mult, then two back-to-back.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (N) cycle("mult1");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("mult1_done");
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    repeat (2 * N) cycle("mult2");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("mult2_done");

    // Branch taken alongside a load-use hazard.
    drive(5, 0, 1, 0, 5, 1, 0, 1);
    cycle("br_lu");
    drive(5, 0, 1, 0, 0, 0, 0, 1);
    cycle("br_flush");

    // Reset while the mult/div counter is at 1.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) cycle("md_pre");
    apply_reset(1);
    cycle("md_rst");
    apply_reset(0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("md_rst_rel");

    // Long stall run pushes the narrow counter into saturation.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (20) cycle("sat");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("sat_idle");

    for (int i = 0; i < 400; i++) begin
      apply_reset($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
